// File: rtl/conv3x3_mac_seq.sv
// Sequencer for the time-multiplexed 3x3 conv MAC: tap counter, capture, frame count.
// Define SAT_OUT_EN for an 8-bit shifted and saturated result instead of the raw 21-bit sum.
module conv3x3_mac_seq #(
  parameter int NUM_WIN = 16,
  parameter int WIN_W   = 16,
  parameter int SHIFT   = 8,
`ifdef SAT_OUT_EN
  localparam int OUT_W  = 8
`else
  localparam int OUT_W  = 21
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    mac_busy,
  output logic [3:0]              cnt,
  input  logic signed [20:0]      mac_sum,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_last,
  output logic [WIN_W-1:0]        win_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_CAPT
  } state_t;

  localparam logic [WIN_W-1:0] LAST_IDX = WIN_W'(NUM_WIN - 1);
  localparam logic [3:0]       TAP_LAST = 4'd8;
  localparam logic [3:0]       TAP_HOLD = 4'd9;

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic                    r_in_ready;
  logic                    r_busy;
  logic                    r_out_valid;
  logic signed [OUT_W-1:0] r_out_data;
  logic                    r_out_last;
  logic [WIN_W-1:0]        r_win_idx;

  logic                    w_free;
  logic                    w_last;
  logic signed [OUT_W-1:0] w_cap;

  assign w_free = !r_out_valid || out_ready;
  assign w_last = (r_win_idx == LAST_IDX);

`ifdef SAT_OUT_EN
  logic signed [20:0] w_shr;

  assign w_shr = mac_sum >>> SHIFT;

  always_comb begin
    w_cap = w_shr[7:0];
    if (w_shr > 21'sd127)
      w_cap = 8'sd127;
    else if (w_shr < -21'sd128)
      w_cap = -8'sd128;
  end
`else
  logic [31:0] w_unused_shift;

  assign w_unused_shift = 32'(SHIFT);
  assign w_cap = mac_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= TAP_HOLD;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_win_idx   <= '0;
    end else begin
      // a capture below overrides this consume
      if (out_ready)
        r_out_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_state    <= S_MAC;
            r_cnt      <= 4'd0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_MAC: begin
          if (r_cnt == TAP_LAST) begin
            r_state <= S_CAPT;
            r_cnt   <= TAP_HOLD;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_CAPT: begin
          if (w_free) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_cap;
            r_out_last  <= w_last;
            r_win_idx   <= w_last ? '0 : r_win_idx + 1'b1;
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_cnt      <= TAP_HOLD;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign mac_busy  = r_busy;
  assign cnt       = r_cnt;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign win_idx   = r_win_idx;

endmodule

// File: tb/tb_conv3x3_mac_seq.sv
// Directed bench for conv3x3_mac_seq with a behavioural MAC datapath.
// Expected results follow the SAT_OUT_EN build setting.
module tb_conv3x3_mac_seq;

`ifdef SAT_OUT_EN
  localparam int OW = 8;
`else
  localparam int OW = 21;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic                 mac_busy;
  logic [3:0]           cnt;
  logic signed [20:0]   mac_sum;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_data;
  logic                 out_last;
  logic [15:0]          win_idx;

  logic signed [7:0]    d [9];
  logic signed [7:0]    w [9];
  logic signed [20:0]   acc;
  logic signed [15:0]   prod;

  int total = 0;
  int bad   = 0;

  conv3x3_mac_seq #(
    .NUM_WIN(4),
    .WIN_W  (16),
    .SHIFT  (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mac_busy (mac_busy),
    .cnt      (cnt),
    .mac_sum  (mac_sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .win_idx  (win_idx)
  );

  always #5 clk = ~clk;

  always_comb begin
    prod = '0;
    if (cnt < 4'd9)
      prod = d[cnt] * w[cnt];
  end

  always @(posedge clk) begin
    if (cnt == 4'd0)
      acc <= 21'(prod);
    else if (cnt < 4'd9)
      acc <= acc + 21'(prod);
  end

  assign mac_sum = acc;

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] pick(input int raw, input int sat);
`ifdef SAT_OUT_EN
    return sat;
`else
    return raw;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_capt();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " cnt"}, 32'(cnt), 9);
    chk({tag, " in_ready"}, 32'(in_ready), 1);
    chk({tag, " mac_busy"}, 32'(mac_busy), 0);
    chk({tag, " out_valid"}, 32'(out_valid), 0);
    chk({tag, " out_data"}, 32'(out_data), 0);
    chk({tag, " out_last"}, 32'(out_last), 0);
    chk({tag, " win_idx"}, 32'(win_idx), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    acc       = '0;
    for (int i = 0; i < 9; i++) begin
      d[i] = 8'(i + 1);
      w[i] = 8'sd1;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    rst_n = 1'b1;
    step();

    // window 1: taps 1..9, weights 1
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("w1 cnt0", 32'(cnt), 0);
    chk("w1 busy", 32'(mac_busy), 1);
    chk("w1 in_ready", 32'(in_ready), 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("w1 cnt%0d", k), 32'(cnt), k);
    end
    step();
    chk("w1 capt cnt", 32'(cnt), 9);
    chk("w1 capt ov", 32'(out_valid), 0);
    step();
    chk("w1 ov", 32'(out_valid), 1);
    chk("w1 data", out_data, pick(45, 0));
    chk("w1 idx", 32'(win_idx), 1);
    chk("w1 last", 32'(out_last), 0);
    chk("w1 in_ready", 32'(in_ready), 1);
    step();
    chk("w1 consumed", 32'(out_valid), 0);

    // window 2 held by backpressure
    for (int i = 0; i < 9; i++) w[i] = 8'sd2;
    out_ready = 1'b0;
    run_to_capt();
    step();
    chk("w2 ov", 32'(out_valid), 1);
    chk("w2 data", out_data, pick(90, 0));
    chk("w2 idx", 32'(win_idx), 2);

    // window 3 stalls in CAPT
    for (int i = 0; i < 9; i++) w[i] = 8'sd3;
    run_to_capt();
    step();
    step();
    chk("bp cnt", 32'(cnt), 9);
    chk("bp in_ready", 32'(in_ready), 0);
    chk("bp busy", 32'(mac_busy), 1);
    chk("bp data", out_data, pick(90, 0));
    chk("bp ov", 32'(out_valid), 1);
    chk("bp idx", 32'(win_idx), 2);
    out_ready = 1'b1;
    step();
    chk("w3 ov", 32'(out_valid), 1);
    chk("w3 data", out_data, pick(135, 0));
    chk("w3 idx", 32'(win_idx), 3);
    chk("w3 last", 32'(out_last), 0);

    // window 4: extremes, last of frame
    for (int i = 0; i < 9; i++) begin
      d[i] = -8'sd128;
      w[i] = -8'sd128;
    end
    run_to_capt();
    step();
    chk("w4 data", out_data, pick(147456, 127));
    chk("w4 last", 32'(out_last), 1);
    chk("w4 idx", 32'(win_idx), 0);

    // window 5: first of next frame, left pending
    for (int i = 0; i < 9; i++) begin
      d[i] = 8'(i + 1);
      w[i] = 8'sd1;
    end
    run_to_capt();
    out_ready = 1'b0;
    step();
    chk("w5 ov", 32'(out_valid), 1);
    chk("w5 data", out_data, pick(45, 0));
    chk("w5 last", 32'(out_last), 0);
    chk("w5 idx", 32'(win_idx), 1);

    // reset in the middle of a pass
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    chk("pre-rst cnt", 32'(cnt), 5);
    rst_n = 1'b0;
    #1;
    chk_reset("mid-rst");
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();

    // window 6: data -128, weights 127
    for (int i = 0; i < 9; i++) begin
      d[i] = -8'sd128;
      w[i] = 8'sd127;
    end
    run_to_capt();
    step();
    chk("w6 data", out_data, pick(-146304, -128));
    chk("w6 idx", 32'(win_idx), 1);
    chk("w6 last", 32'(out_last), 0);

    // window 7: sum of -1
    for (int i = 0; i < 9; i++) begin
      d[i] = 8'sd0;
      w[i] = 8'sd1;
    end
    d[0] = -8'sd1;
    run_to_capt();
    step();
    chk("w7 data", out_data, pick(-1, -1));
    chk("w7 idx", 32'(win_idx), 2);
    step();
    chk("w7 consumed", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
